// File: rtl/ptp_rx_parser.sv
// ptp_rx_parser: parses IEEE1588v2 headers from the PTP UDP payload byte stream and queues one
// {msgType, seqId, sec, ns} record per valid frame; firmware reads and pops records over Wishbone.
// Latency: record visible in STATUS 2 cycles after the tlast beat. Backpressure: none, tready=1 after reset.
// Optional feature macro PTP_RX_TUSER_EN adds s_axis_tuser; tuser on the tlast beat drops the frame.
module ptp_rx_parser #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
`ifdef PTP_RX_TUSER_EN
   input  logic        s_axis_tuser,
`endif
   input  logic [31:0] wbs_addr_i,
   input  logic [31:0] wbs_data_i,
   output logic [31:0] wbs_data_o,
   input  logic        wbs_we_i,
   input  logic        wbs_stb_i,
   output logic        wbs_ack_o,
   output logic        rx_irq_o
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [3:0]  msg_type;
      logic [15:0] seq_id;
      logic [31:0] sec;
      logic [31:0] ns;
   } rec_t;

   typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, COMMIT = 2'd2} state_t;

   state_t          state_q, state_nxt;
   rec_t            rec_q;
   rec_t            head;
   rec_t            mem_q [FIFO_DEPTH];
   logic [3:0]      version_q;
   logic [5:0]      idx_q, cur_idx;
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [4:0]      count_q, count_nxt;
   logic [15:0]     drop_cnt_q;
   logic [31:0]     rx_cnt_q;
   logic            ovf_q;
   logic            beat, type_ok, frame_ok, tuser_err;
   logic            push_req, frame_drop, push_ok, ovf_evt, pop;
   logic            not_empty, full;
   logic            wb_fire, ovf_clr;
   logic [2:0]      reg_sel;
   logic [31:0]     rdata;
   logic            unused_bits;

`ifdef PTP_RX_TUSER_EN
   assign tuser_err = s_axis_tuser;
`else
   assign tuser_err = 1'b0;
`endif

   assign beat      = s_axis_tvalid & s_axis_tready;
   // A beat seen outside HDR is always byte 0 of a new frame.
   assign cur_idx   = (state_q == HDR) ? idx_q : 6'd0;
   assign type_ok   = (rec_q.msg_type == 4'h0) | (rec_q.msg_type == 4'h1) |
                      (rec_q.msg_type == 4'h8) | (rec_q.msg_type == 4'h9);
   assign frame_ok  = (cur_idx >= 6'd43) & (version_q == 4'd2) & type_ok & ~tuser_err;

   assign not_empty = (count_q != 5'd0);
   assign full      = (count_q == 5'(FIFO_DEPTH));
   assign head      = mem_q[rd_ptr_q];

   assign reg_sel   = wbs_addr_i[4:2];
   assign wb_fire   = wbs_stb_i & ~wbs_ack_o;
   assign pop       = wb_fire & wbs_we_i & (reg_sel == 3'd4) & not_empty;
   assign ovf_clr   = wb_fire & wbs_we_i & (reg_sel == 3'd0) & wbs_data_i[1];
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign push_ok   = push_req & (~full | pop);
   assign ovf_evt   = push_req & full & ~pop;

   assign unused_bits = &{1'b0, wbs_addr_i[31:5], wbs_addr_i[1:0], wbs_data_i[31:2], wbs_data_i[0]};

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_nxt;
   end

   // FSM next state: frames end on tlast, valid ones take one COMMIT cycle
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE, COMMIT: state_nxt = (beat && !s_axis_tlast) ? HDR : IDLE;
         HDR:          if (beat && s_axis_tlast) state_nxt = frame_ok ? COMMIT : IDLE;
         default:      state_nxt = IDLE;
      endcase
   end

   // FSM outputs: push request in COMMIT, drop on any frame ending without qualifying
   always_comb begin
      push_req   = 1'b0;
      frame_drop = 1'b0;
      case (state_q)
         IDLE, COMMIT: frame_drop = beat & s_axis_tlast;
         HDR:          frame_drop = beat & s_axis_tlast & ~frame_ok;
         default:      frame_drop = 1'b0;
      endcase
      if (state_q == COMMIT) push_req = 1'b1;
   end

   // Byte index and header field capture
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q     <= 6'd0;
         version_q <= 4'd0;
         rec_q     <= '0;
      end else if (beat) begin
         idx_q <= (cur_idx == 6'd63) ? 6'd63 : cur_idx + 6'd1;
         case (cur_idx)
            6'd0:  rec_q.msg_type      <= s_axis_tdata[3:0];
            6'd1:  version_q           <= s_axis_tdata[3:0];
            6'd30: rec_q.seq_id[15:8]  <= s_axis_tdata;
            6'd31: rec_q.seq_id[7:0]   <= s_axis_tdata;
            6'd36: rec_q.sec[31:24]    <= s_axis_tdata;
            6'd37: rec_q.sec[23:16]    <= s_axis_tdata;
            6'd38: rec_q.sec[15:8]     <= s_axis_tdata;
            6'd39: rec_q.sec[7:0]      <= s_axis_tdata;
            6'd40: rec_q.ns[31:24]     <= s_axis_tdata;
            6'd41: rec_q.ns[23:16]     <= s_axis_tdata;
            6'd42: rec_q.ns[15:8]      <= s_axis_tdata;
            6'd43: rec_q.ns[7:0]       <= s_axis_tdata;
            default: ;
         endcase
      end
   end

   // Record storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= rec_q;
   end

   // Next occupancy, shared by the count register and the interrupt
   always_comb begin
      count_nxt = count_q;
      if (push_ok && !pop)      count_nxt = count_q + 5'd1;
      else if (pop && !push_ok) count_nxt = count_q - 5'd1;
   end

   // FIFO pointers, counters, overflow flag, interrupt and stream ready
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= 5'd0;
         drop_cnt_q    <= 16'd0;
         rx_cnt_q      <= 32'd0;
         ovf_q         <= 1'b0;
         rx_irq_o      <= 1'b0;
         s_axis_tready <= 1'b0;
      end else begin
         s_axis_tready <= 1'b1;
         count_q       <= count_nxt;
         rx_irq_o      <= (count_nxt != 5'd0);
         drop_cnt_q    <= drop_cnt_q + 16'(frame_drop) + 16'(ovf_evt);
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            rx_cnt_q <= rx_cnt_q + 32'd1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         if (ovf_evt)      ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
      end
   end

   // Register read mux; head fields read as 0 when nothing is queued
   always_comb begin
      rdata = 32'd0;
      case (reg_sel)
         3'd0:    rdata = {drop_cnt_q, 8'd0, count_q[3:0], 2'b00, ovf_q, not_empty};
         3'd1:    if (not_empty) rdata = {head.seq_id, 12'd0, head.msg_type};
         3'd2:    if (not_empty) rdata = head.sec;
         3'd3:    if (not_empty) rdata = head.ns;
         3'd5:    rdata = rx_cnt_q;
         default: rdata = 32'd0;
      endcase
   end

   // Wishbone acknowledge and registered read data, one ack per strobe acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         wbs_ack_o  <= 1'b0;
         wbs_data_o <= 32'd0;
      end else begin
         wbs_ack_o  <= wb_fire;
         wbs_data_o <= wb_fire ? rdata : 32'd0;
      end
   end
endmodule

// File: tb/tb_ptp_rx_parser.sv
// tb_ptp_rx_parser: directed frames and Wishbone accesses against ptp_rx_parser.
// Expected register values are queued at issue time and compared by a monitor on each ack.
// Build with PTP_RX_TUSER_EN defined to include the tuser drop case.
module tb_ptp_rx_parser;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        s_axis_tlast;
`ifdef PTP_RX_TUSER_EN
   logic        s_axis_tuser;
   bit          tu_req = 1'b0;
`endif
   logic [31:0] wbs_addr_i;
   logic [31:0] wbs_data_i;
   logic [31:0] wbs_data_o;
   logic        wbs_we_i;
   logic        wbs_stb_i;
   logic        wbs_ack_o;
   logic        rx_irq_o;

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] exp_q [$];
   bit          chk_q [$];
   string       name_q [$];
   logic [7:0]  fb [64];

   always #5 clk = ~clk;

   ptp_rx_parser #(.FIFO_DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
`ifdef PTP_RX_TUSER_EN
      .s_axis_tuser  (s_axis_tuser),
`endif
      .wbs_addr_i    (wbs_addr_i),
      .wbs_data_i    (wbs_data_i),
      .wbs_data_o    (wbs_data_o),
      .wbs_we_i      (wbs_we_i),
      .wbs_stb_i     (wbs_stb_i),
      .wbs_ack_o     (wbs_ack_o),
      .rx_irq_o      (rx_irq_o)
   );

   // Monitor: every ack consumes one scoreboard entry
   always @(negedge clk) begin
      if (wbs_ack_o) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_ack data=%h", wbs_data_o);
         end else begin
            logic [31:0] e;
            bit          c;
            string       nm;
            e  = exp_q.pop_front();
            c  = chk_q.pop_front();
            nm = name_q.pop_front();
            if (c) begin
               n_chk++;
               if (wbs_data_o !== e) begin
                  n_err++;
                  $display("FAIL %s got=%h want=%h", nm, wbs_data_o, e);
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", nm, act, want);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wb_xfer(input logic [2:0] rs, input bit we, input logic [31:0] wd,
                          input bit c, input logic [31:0] want, input string nm);
      exp_q.push_back(want);
      chk_q.push_back(c);
      name_q.push_back(nm);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
`ifdef PTP_RX_TUSER_EN
      s_axis_tuser  = 1'b0;
`endif
      wbs_stb_i  = 1'b1;
      wbs_we_i   = we;
      wbs_addr_i = {27'd0, rs, 2'b00};
      wbs_data_i = wd;
      @(negedge clk);
      chk({nm, "_ack"}, 32'(wbs_ack_o), 32'd1);
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
   endtask

   task automatic rd(input logic [2:0] rs, input logic [31:0] want, input string nm);
      wb_xfer(rs, 1'b0, 32'd0, 1'b1, want, nm);
   endtask

   task automatic wr(input logic [2:0] rs, input logic [31:0] wd, input string nm);
      wb_xfer(rs, 1'b1, wd, 1'b0, 32'd0, nm);
   endtask

   task automatic build_frame(input logic [3:0] mt, input logic [3:0] ver, input logic [15:0] seq,
                              input logic [31:0] sec, input logic [31:0] ns);
      for (int i = 0; i < 64; i++) fb[i] = 8'(8'hC0 + i);
      fb[0]  = {4'h0, mt};
      fb[1]  = {4'h0, ver};
      fb[30] = seq[15:8];
      fb[31] = seq[7:0];
      fb[34] = 8'hEE;
      fb[35] = 8'hEE;
      fb[36] = sec[31:24];
      fb[37] = sec[23:16];
      fb[38] = sec[15:8];
      fb[39] = sec[7:0];
      fb[40] = ns[31:24];
      fb[41] = ns[23:16];
      fb[42] = ns[15:8];
      fb[43] = ns[7:0];
   endtask

   task automatic send_bytes(input int n, input bit with_last, input bit b2b);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = fb[i];
         s_axis_tlast  = with_last && (i == n - 1);
`ifdef PTP_RX_TUSER_EN
         s_axis_tuser  = tu_req && (i == n - 1);
`endif
      end
      if (!b2b) begin
         @(negedge clk);
         s_axis_tvalid = 1'b0;
         s_axis_tlast  = 1'b0;
`ifdef PTP_RX_TUSER_EN
         s_axis_tuser  = 1'b0;
`endif
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      wbs_stb_i     = 1'b0;
      idle(2);
      chk("rst_tready", 32'(s_axis_tready), 32'd0);
      chk("rst_irq", 32'(rx_irq_o), 32'd0);
      rst = 1'b0;
      idle(2);
   endtask

   initial begin
      rst           = 1'b1;
      s_axis_tdata  = 8'd0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
`ifdef PTP_RX_TUSER_EN
      s_axis_tuser  = 1'b0;
`endif
      wbs_addr_i = 32'd0;
      wbs_data_i = 32'd0;
      wbs_we_i   = 1'b0;
      wbs_stb_i  = 1'b0;

      // Reset state
      do_reset();
      chk("post_rst_tready", 32'(s_axis_tready), 32'd1);
      chk("post_rst_ack", 32'(wbs_ack_o), 32'd0);
      chk("post_rst_data", wbs_data_o, 32'd0);
      rd(3'd0, 32'h0000_0000, "status_rst");
      rd(3'd5, 32'h0000_0000, "rxcnt_rst");

      // Single Sync frame
      build_frame(4'h0, 4'd2, 16'h1234, 32'h0000_0005, 32'h3B9A_C9FF);
      send_bytes(44, 1'b1, 1'b0);
      idle(2);
      chk("sync_irq", 32'(rx_irq_o), 32'd1);
      rd(3'd0, 32'h0000_0011, "sync_status");
      rd(3'd1, 32'h1234_0000, "sync_msg");
      rd(3'd2, 32'h0000_0005, "sync_sec");
      rd(3'd3, 32'h3B9A_C9FF, "sync_ns");
      rd(3'd5, 32'h0000_0001, "sync_rxcnt");
      rd(3'd6, 32'h0000_0000, "reg6_zero");
      rd(3'd4, 32'h0000_0000, "pop_read_zero");
      wr(3'd4, 32'd0, "pop");
      rd(3'd0, 32'h0000_0000, "pop_status");
      idle(1);
      chk("pop_irq", 32'(rx_irq_o), 32'd0);
      wr(3'd4, 32'd0, "pop_empty");
      rd(3'd0, 32'h0000_0000, "pop_empty_status");
      rd(3'd1, 32'h0000_0000, "empty_msg");
      rd(3'd5, 32'h0000_0001, "pop_empty_rxcnt");

      // Bad version, bad type, short frame
      do_reset();
      build_frame(4'h0, 4'd1, 16'h0001, 32'd1, 32'd1);
      send_bytes(44, 1'b1, 1'b0);
      build_frame(4'hB, 4'd2, 16'h0002, 32'd2, 32'd2);
      send_bytes(44, 1'b1, 1'b0);
      build_frame(4'h0, 4'd2, 16'h0003, 32'd3, 32'd3);
      send_bytes(20, 1'b1, 1'b0);
      idle(2);
      rd(3'd0, 32'h0003_0000, "drop_status");
      rd(3'd5, 32'h0000_0000, "drop_rxcnt");
      chk("drop_irq", 32'(rx_irq_o), 32'd0);

      // Overflow with six Delay_Req frames
      do_reset();
      for (int s = 1; s <= 6; s++) begin
         build_frame(4'h1, 4'd2, 16'(s), 32'(s), 32'(s * 1000));
         send_bytes(44, 1'b1, 1'b0);
         idle(1);
      end
      idle(2);
      rd(3'd0, 32'h0002_0043, "ovf_status");
      rd(3'd1, 32'h0001_0001, "ovf_head_msg");
      rd(3'd2, 32'h0000_0001, "ovf_head_sec");
      rd(3'd5, 32'h0000_0004, "ovf_rxcnt");
      wr(3'd0, 32'h0000_0002, "ovf_clear");
      rd(3'd0, 32'h0002_0041, "ovf_cleared");
      wr(3'd4, 32'd0, "ovf_pop");
      rd(3'd0, 32'h0002_0031, "ovf_pop_status");
      rd(3'd1, 32'h0002_0001, "ovf_second_msg");
      rd(3'd3, 32'h0000_07D0, "ovf_second_ns");

      // Back-to-back frames, pop lands in the second frame's commit cycle
      do_reset();
      build_frame(4'h8, 4'd2, 16'h00A1, 32'h0000_000A, 32'h0000_00AA);
      send_bytes(44, 1'b1, 1'b1);
      build_frame(4'h9, 4'd2, 16'h00B2, 32'h0000_000B, 32'h0000_00BB);
      send_bytes(44, 1'b1, 1'b1);
      wr(3'd4, 32'd0, "b2b_pop");
      idle(1);
      rd(3'd0, 32'h0000_0011, "b2b_status");
      rd(3'd1, 32'h00B2_0009, "b2b_msg");
      rd(3'd3, 32'h0000_00BB, "b2b_ns");
      rd(3'd5, 32'h0000_0002, "b2b_rxcnt");

      // Reset in the middle of a frame
      do_reset();
      build_frame(4'h0, 4'd2, 16'h0777, 32'd7, 32'd7);
      send_bytes(44, 1'b1, 1'b0);
      idle(2);
      rd(3'd0, 32'h0000_0011, "pre_rst_status");
      build_frame(4'h0, 4'd2, 16'h0888, 32'd8, 32'd8);
      send_bytes(20, 1'b0, 1'b1);
      do_reset();
      rd(3'd0, 32'h0000_0000, "midrst_status");
      rd(3'd5, 32'h0000_0000, "midrst_rxcnt");
      build_frame(4'h9, 4'd2, 16'h5555, 32'h0000_0055, 32'h5555_0000);
      send_bytes(44, 1'b1, 1'b0);
      idle(2);
      rd(3'd0, 32'h0000_0011, "after_rst_status");
      rd(3'd1, 32'h5555_0009, "after_rst_msg");
      rd(3'd2, 32'h0000_0055, "after_rst_sec");
      rd(3'd3, 32'h5555_0000, "after_rst_ns");
      rd(3'd5, 32'h0000_0001, "after_rst_rxcnt");

`ifdef PTP_RX_TUSER_EN
      // Errored frame flagged on the last beat
      do_reset();
      build_frame(4'h0, 4'd2, 16'h0999, 32'd9, 32'd9);
      tu_req = 1'b1;
      send_bytes(44, 1'b1, 1'b0);
      tu_req = 1'b0;
      idle(2);
      rd(3'd0, 32'h0001_0000, "tuser_status");
      rd(3'd5, 32'h0000_0000, "tuser_rxcnt");
`endif

      idle(4);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
